// File: rtl/regfile_writer_pkg.sv
// regfile_writer_pkg: shared widths, the zero register and the FIFO entry record.
package regfile_writer_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } entry_t;
endpackage

// File: rtl/regfile_writer_fifo.sv
// regfile_writer_fifo: circular buffer with per-entry valid bits, squash by address and youngest-match lookup.
module regfile_writer_fifo
  import regfile_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  entry_t                   i_push_e,
  input  logic                     i_pop,
  input  logic                     i_sq_en,
  input  logic [AW-1:0]            i_sq_wa,
  input  logic [AW-1:0]            i_ra1,
  input  logic [AW-1:0]            i_ra2,
  output entry_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_hit1,
  output logic                     o_hit2,
  output logic [DW-1:0]            o_d1,
  output logic [DW-1:0]            o_d2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count;
  entry_t          w_new;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;
  // A squash in the same cycle as the push must also kill the incoming entry.
  always_comb begin
    w_new       = i_push_e;
    w_new.valid = i_push_e.valid && !(i_sq_en && i_push_e.wa == i_sq_wa);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_sq_en && r_mem[i].wa == i_sq_wa) r_mem[i].valid <= 1'b0;
      if (i_push) begin
        r_mem[r_wp] <= w_new;
        r_wp        <= r_wp + PW'(1);
      end
      if (i_pop) r_rp <= r_rp + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    o_hit1 = 1'b0;
    o_hit2 = 1'b0;
    o_d1   = '0;
    o_d2   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count && r_mem[r_rp + PW'(k)].valid) begin
        if (r_mem[r_rp + PW'(k)].wa == i_ra1) begin
          o_hit1 = 1'b1;
          o_d1   = r_mem[r_rp + PW'(k)].wd;
        end
        if (r_mem[r_rp + PW'(k)].wa == i_ra2) begin
          o_hit2 = 1'b1;
          o_d2   = r_mem[r_rp + PW'(k)].wd;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: owns the regfile write port, merging pipeline writeback with buffered long-latency results.
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [AW-1:0]          pipe_wa,
  input  logic [DW-1:0]          pipe_wd,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [AW-1:0]          lu_wa,
  input  logic [DW-1:0]          lu_wd,
  output logic                   we3,
  output logic [AW-1:0]          wa3,
  output logic [DW-1:0]          wd3,
  input  logic [AW-1:0]          fwd_ra1,
  input  logic [AW-1:0]          fwd_ra2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_d1,
  output logic [DW-1:0]          fwd_d2,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic          w_grant, w_pop, w_push, w_empty;
  logic          w_hit1, w_hit2, w_oreg1, w_oreg2;
  logic [DW-1:0] w_d1, w_d2;
  entry_t        w_head, w_push_e;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  assign w_grant   = pipe_we && pipe_wa != REG_ZERO;
  assign w_empty   = count == '0;
  assign w_pop     = !w_grant && !w_empty;
  assign lu_ready  = count < CW'(DEPTH) && !rst;
  assign w_push    = lu_valid && lu_ready && lu_wa != REG_ZERO;
  assign w_push_e  = {1'b1, lu_wa, lu_wd};
  assign w_cnt_nxt = count + CW'(w_push) - CW'(w_pop);
  // Saturates at the limit; only the threshold comparison matters.
  assign w_starve_nxt = (w_grant && !w_empty)
                      ? ((r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1))
                      : '0;
  regfile_writer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_push_e (w_push_e),
    .i_pop    (w_pop),
    .i_sq_en  (w_grant),
    .i_sq_wa  (pipe_wa),
    .i_ra1    (fwd_ra1),
    .i_ra2    (fwd_ra2),
    .o_head   (w_head),
    .o_count  (count),
    .o_hit1   (w_hit1),
    .o_hit2   (w_hit2),
    .o_d1     (w_d1),
    .o_d2     (w_d2)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      r_starve  <= '0;
      stall_req <= 1'b0;
    end else begin
      we3 <= w_grant || (w_pop && w_head.valid);
      if (w_grant) begin
        wa3 <= pipe_wa;
        wd3 <= pipe_wd;
      end else if (w_pop) begin
        wa3 <= w_head.wa;
        wd3 <= w_head.wd;
      end
      r_starve  <= w_starve_nxt;
      stall_req <= w_cnt_nxt != '0 &&
                   (stall_req || w_starve_nxt >= SW'(STARVE_LIMIT) || w_cnt_nxt == CW'(DEPTH));
    end
  end
  always_comb begin
    w_oreg1  = we3 && wa3 == fwd_ra1;
    w_oreg2  = we3 && wa3 == fwd_ra2;
    fwd_hit1 = fwd_ra1 != REG_ZERO && (w_hit1 || w_oreg1);
    fwd_hit2 = fwd_ra2 != REG_ZERO && (w_hit2 || w_oreg2);
    fwd_d1   = fwd_ra1 == REG_ZERO ? '0 : w_hit1 ? w_d1 : w_oreg1 ? wd3 : '0;
    fwd_d2   = fwd_ra2 == REG_ZERO ? '0 : w_hit2 ? w_d2 : w_oreg2 ? wd3 : '0;
  end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: queue-based reference model with a scoreboard of registered outputs and direct forwarding checks.
module tb_regfile_writer;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0, lu_valid = 1'b0;
  logic [4:0]  pipe_wa = '0, lu_wa = '0, fwd_ra1 = '0, fwd_ra2 = '0;
  logic [31:0] pipe_wd = '0, lu_wd = '0;
  logic        lu_ready, we3, fwd_hit1, fwd_hit2, stall_req;
  logic [4:0]  wa3;
  logic [31:0] wd3, fwd_d1, fwd_d2;
  logic [2:0]  count;
  always #5 clk = ~clk;
  regfile_writer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2),
    .stall_req(stall_req), .count(count)
  );
  typedef struct {bit v; bit [4:0] wa; bit [31:0] wd;} ment_t;
  typedef struct {bit we; bit [4:0] wa; bit [31:0] wd; int cnt; bit stall;} exp_t;
  ment_t       mq[$];
  exp_t        sb[$];
  bit          m_we, m_stall, m_ok;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;
  int          m_starve;
  int          checks = 0, passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
  endtask
  function automatic logic [32:0] mfwd(input bit [4:0] ra);
    if (ra == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].v && mq[i].wa == ra) return {1'b1, mq[i].wd};
    if (m_we && m_wa == ra) return {1'b1, m_wd};
    return '0;
  endfunction
  // One clock: drive at negedge, check combinational outputs, advance the model, queue the expectation.
  task automatic cyc(input bit r, input bit pw, input bit [4:0] pwa, input bit [31:0] pwd,
                     input bit lv, input bit [4:0] lwa, input bit [31:0] lwd,
                     input bit [4:0] r1, input bit [4:0] r2);
    bit g, push;
    int n0;
    ment_t e;
    logic [32:0] f1, f2;
    rst = r; pipe_we = pw; pipe_wa = pwa; pipe_wd = pwd;
    lu_valid = lv; lu_wa = lwa; lu_wd = lwd; fwd_ra1 = r1; fwd_ra2 = r2;
    #1;
    if (m_ok || r) chk("lu_ready", lu_ready, !r && mq.size() < DEPTH);
    if (m_ok) begin
      f1 = mfwd(r1);
      f2 = mfwd(r2);
      chk("fwd_hit1", fwd_hit1, f1[32]);
      chk("fwd_d1", fwd_d1, f1[31:0]);
      chk("fwd_hit2", fwd_hit2, f2[32]);
      chk("fwd_d2", fwd_d2, f2[31:0]);
    end
    if (r) begin
      mq.delete();
      m_we = 0; m_wa = 0; m_wd = 0; m_starve = 0; m_stall = 0; m_ok = 1;
    end else begin
      g    = pw && pwa != 0;
      n0   = mq.size();
      push = lv && n0 < DEPTH && lwa != 0;
      if (g) begin
        m_we = 1; m_wa = pwa; m_wd = pwd;
        foreach (mq[i]) if (mq[i].wa == pwa) mq[i].v = 0;
      end else if (n0 > 0) begin
        e = mq.pop_front();
        m_we = e.v;
        if (e.v) begin m_wa = e.wa; m_wd = e.wd; end
      end else m_we = 0;
      if (push) mq.push_back('{v: !(g && lwa == pwa), wa: lwa, wd: lwd});
      m_starve = (n0 > 0 && g) ? m_starve + 1 : 0;
      m_stall  = mq.size() == 0 ? 0 : (m_stall || m_starve >= LIMIT || mq.size() == DEPTH);
    end
    sb.push_back('{we: m_we, wa: m_wa, wd: m_wd, cnt: mq.size(), stall: m_stall});
    @(negedge clk);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("we3", we3, e.we);
        if (e.we) begin
          chk("wa3", wa3, e.wa);
          chk("wd3", wd3, e.wd);
        end
        chk("count", count, e.cnt);
        chk("stall_req", stall_req, e.stall);
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : stim
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we3", we3, 0);
    chk("rst_count", count, 0);
    chk("rst_stall", stall_req, 0);
    cyc(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    chk("pipe_wa3", wa3, 3);
    chk("pipe_wd3", wd3, 32'h11);
    fwd_ra1 = 3;
    #1;
    chk("pipe_fwd_hit", fwd_hit1, 1);
    chk("pipe_fwd_d", fwd_d1, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 1, 7, 32'hAA, 7, 0);
    chk("lu_count1", count, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("lu_drain_wa3", wa3, 7);
    chk("lu_drain_wd3", wd3, 32'hAA);
    for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 1, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i, 5'(10 + i), 1);
    chk("fill_stall", stall_req, 1);
    chk("fill_ready", lu_ready, 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 5'(10 + i), 13);
    chk("drained_stall", stall_req, 0);
    chk("drained_ready", lu_ready, 1);
    cyc(0, 1, 1, 32'h3, 1, 5, 32'h1, 5, 0);
    cyc(0, 1, 5, 32'h2, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 5);
    chk("squash_we3", we3, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 5);
    chk("zero_lu_count", count, 0);
    cyc(0, 1, 1, 32'h4, 1, 9, 32'h99, 9, 0);
    cyc(0, 1, 0, 32'h5, 0, 0, 0, 9, 0);
    chk("zero_pipe_drain_wa3", wa3, 9);
    for (int i = 0; i < 12; i++) cyc(0, 1, 2, 32'h300 + i, i < 3, 5'(20 + i), 32'h400 + i, 20, 2);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_stall", stall_req, 1);
    cyc(1, 0, 0, 0, 1, 4, 32'h1, 20, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_stall", stall_req, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 20, 0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 500; i++) begin
        int pct;
        bit pw;
        pct = 20 + p * 25;
        pw  = m_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < pct);
        cyc($urandom_range(0, 299) == 0, pw, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
